// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU with RV32M multiply/divide.
package alu_pkg;

    localparam int unsigned OPSEL_W = 3;

    // Base-op selector
    localparam logic [OPSEL_W-1:0] OP_ADD     = 3'b000;
    localparam logic [OPSEL_W-1:0] OP_SLL     = 3'b001;
    localparam logic [OPSEL_W-1:0] OP_SLT     = 3'b010;
    localparam logic [OPSEL_W-1:0] OP_SLT_ALT = 3'b011;
    localparam logic [OPSEL_W-1:0] OP_XOR     = 3'b100;
    localparam logic [OPSEL_W-1:0] OP_SR      = 3'b101;
    localparam logic [OPSEL_W-1:0] OP_OR      = 3'b110;
    localparam logic [OPSEL_W-1:0] OP_AND     = 3'b111;

    // M-extension funct3
    localparam logic [OPSEL_W-1:0] F3_MUL    = 3'b000;
    localparam logic [OPSEL_W-1:0] F3_MULH   = 3'b001;
    localparam logic [OPSEL_W-1:0] F3_MULHSU = 3'b010;
    localparam logic [OPSEL_W-1:0] F3_MULHU  = 3'b011;
    localparam logic [OPSEL_W-1:0] F3_DIV    = 3'b100;
    localparam logic [OPSEL_W-1:0] F3_DIVU   = 3'b101;
    localparam logic [OPSEL_W-1:0] F3_REM    = 3'b110;
    localparam logic [OPSEL_W-1:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/muldiv_core.sv
// Iterative shift-add multiplier and restoring divider sharing one 2*XLEN register.
module muldiv_core
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [OPSEL_W-1:0] i_funct3,
    input  logic [XLEN-1:0]    i_op1,
    input  logic [XLEN-1:0]    i_op2,
    output logic               o_special_c,
    output logic [XLEN-1:0]    o_special_result_c,
    output logic               o_last_c,
    output logic [XLEN-1:0]    o_result_c
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = SHW + 1;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    logic                  is_div;
    logic                  sgn1;
    logic                  sgn2;
    logic                  neg1;
    logic                  neg2;
    logic [XLEN-1:0]       mag1;
    logic [XLEN-1:0]       mag2;

    // acc_q: {high product, multiplier} for MUL*, {remainder, quotient} for DIV*
    logic [2*XLEN-1:0]     acc_q;
    logic [XLEN-1:0]       opb_q;
    logic [OPSEL_W-1:0]    f3_q;
    logic                  neg_q_q;
    logic                  neg_r_q;
    logic [CW-1:0]         cnt_q;

    logic [XLEN:0]         add_sum;
    logic [XLEN:0]         div_shift;
    logic [XLEN:0]         div_trial;
    logic                  div_ge;
    logic [2*XLEN-1:0]     acc_nxt;
    logic [2*XLEN-1:0]     prod_fix;
    logic [XLEN-1:0]       quo;
    logic [XLEN-1:0]       rem;

    // Operand signedness and magnitudes
    assign is_div = i_funct3[2];
    assign sgn1   = is_div ? ~i_funct3[0] : (i_funct3 != F3_MULHU);
    assign sgn2   = is_div ? ~i_funct3[0] : ~i_funct3[1];
    assign neg1   = sgn1 & i_op1[XLEN-1];
    assign neg2   = sgn2 & i_op2[XLEN-1];
    assign mag1   = neg1 ? -i_op1 : i_op1;
    assign mag2   = neg2 ? -i_op2 : i_op2;

    // Divide-by-zero and signed overflow finish without iterating
    always_comb begin
        o_special_c        = 1'b0;
        o_special_result_c = '0;
        if (is_div && (i_op2 == '0)) begin
            o_special_c        = 1'b1;
            o_special_result_c = i_funct3[1] ? i_op1 : '1;
        end else if (is_div && !i_funct3[0] && (i_op1 == MIN_INT) && (i_op2 == '1)) begin
            o_special_c        = 1'b1;
            o_special_result_c = i_funct3[1] ? '0 : MIN_INT;
        end
    end

    // One iteration step of either unit
    always_comb begin
        add_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_trial = div_shift - {1'b0, opb_q};
        div_ge    = ~div_trial[XLEN];
        if (f3_q[2]) begin
            acc_nxt = {(div_ge ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0]),
                       acc_q[XLEN-2:0], div_ge};
        end else begin
            acc_nxt = {add_sum, acc_q[XLEN-1:1]};
        end
    end

    // Sign fix and result select, applied to the final step's value
    always_comb begin
        prod_fix = neg_q_q ? -acc_nxt : acc_nxt;
        quo      = acc_nxt[XLEN-1:0];
        rem      = acc_nxt[2*XLEN-1:XLEN];
        if (f3_q[2]) begin
            if (f3_q[1]) begin
                o_result_c = neg_r_q ? -rem : rem;
            end else begin
                o_result_c = neg_q_q ? -quo : quo;
            end
        end else if (f3_q == F3_MUL) begin
            o_result_c = prod_fix[XLEN-1:0];
        end else begin
            o_result_c = prod_fix[2*XLEN-1:XLEN];
        end
    end

    assign o_last_c = (cnt_q == CW'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q   <= '0;
            opb_q   <= '0;
            f3_q    <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            cnt_q   <= '0;
        end else if (i_start) begin
            acc_q   <= {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
            opb_q   <= is_div ? mag2 : mag1;
            f3_q    <= i_funct3;
            neg_q_q <= neg1 ^ neg2;
            neg_r_q <= neg1;
            cnt_q   <= CW'(XLEN);
        end else if (cnt_q != '0) begin
            acc_q   <= acc_nxt;
            cnt_q   <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU: registered single-cycle base ops plus iterative RV32M behind valid/ready.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_mext,
    input  logic [OPSEL_W-1:0] i_opsel,
    input  logic               i_sub,
    input  logic               i_unsigned,
    input  logic               i_arith,
    input  logic [XLEN-1:0]    i_op1,
    input  logic [XLEN-1:0]    i_op2,
    output logic               o_valid,
    output logic [XLEN-1:0]    o_result,
    output logic               o_eq,
    output logic               o_slt
);

    localparam int unsigned SHW = $clog2(XLEN);

    state_e            state_q;
    state_e            state_d;
    logic              can_accept;
    logic              accept;
    logic              busy;
    logic [SHW-1:0]    shamt;
    logic              op_eq;
    logic              op_lt;
    logic [XLEN-1:0]   base_res;
    logic              pend_eq_q;
    logic              pend_slt_q;

    logic              core_start;
    logic              core_special_c;
    logic [XLEN-1:0]   core_special_res_c;
    logic              core_last_c;
    logic [XLEN-1:0]   core_result_c;

    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign o_ready    = can_accept & ~i_rst;
    assign accept     = i_valid & o_ready;
    assign busy       = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign core_start = accept & i_mext & ~core_special_c;

    assign shamt = i_op2[SHW-1:0];
    assign op_eq = (i_op1 == i_op2);
    assign op_lt = i_unsigned ? (i_op1 < i_op2) : ($signed(i_op1) < $signed(i_op2));

    // Base-op datapath
    always_comb begin
        base_res = '0;
        case (i_opsel)
            OP_ADD:             base_res = i_sub ? (i_op1 - i_op2) : (i_op1 + i_op2);
            OP_SLL:             base_res = i_op1 << shamt;
            OP_SLT, OP_SLT_ALT: base_res = XLEN'(op_lt);
            OP_XOR:             base_res = i_op1 ^ i_op2;
            OP_SR:              base_res = i_arith ? XLEN'($signed(i_op1) >>> shamt)
                                                   : (i_op1 >> shamt);
            OP_OR:              base_res = i_op1 | i_op2;
            OP_AND:             base_res = i_op1 & i_op2;
            default:            base_res = '0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    if (!i_mext || core_special_c) begin
                        state_d = ST_DONE;
                    end else if (i_opsel[2]) begin
                        state_d = ST_DIV;
                    end else begin
                        state_d = ST_MUL;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (core_last_c) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            o_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            o_valid <= (state_d == ST_DONE);
        end
    end

    // Result registers; compare flags of an iterative op wait for its result
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_result   <= '0;
            o_eq       <= 1'b0;
            o_slt      <= 1'b0;
            pend_eq_q  <= 1'b0;
            pend_slt_q <= 1'b0;
        end else if (accept && (!i_mext || core_special_c)) begin
            o_result <= i_mext ? core_special_res_c : base_res;
            o_eq     <= op_eq;
            o_slt    <= op_lt;
        end else if (accept) begin
            pend_eq_q  <= op_eq;
            pend_slt_q <= op_lt;
        end else if (busy && core_last_c) begin
            o_result <= core_result_c;
            o_eq     <= pend_eq_q;
            o_slt    <= pend_slt_q;
        end
    end

    muldiv_core #(
        .XLEN (XLEN)
    ) u_core (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_start            (core_start),
        .i_funct3           (i_opsel),
        .i_op1              (i_op1),
        .i_op2              (i_op2),
        .o_special_c        (core_special_c),
        .o_special_result_c (core_special_res_c),
        .o_last_c           (core_last_c),
        .o_result_c         (core_result_c)
    );

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed table, multi-cycle corner sequences, random vs. model.
module tb_alu_mdu;

    localparam int unsigned XLEN = 32;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_valid;
    logic              o_ready;
    logic              i_mext;
    logic [2:0]        i_opsel;
    logic              i_sub;
    logic              i_unsigned;
    logic              i_arith;
    logic [XLEN-1:0]   i_op1;
    logic [XLEN-1:0]   i_op2;
    logic              o_valid;
    logic [XLEN-1:0]   o_result;
    logic              o_eq;
    logic              o_slt;

    int errors = 0;
    int checks = 0;

    alu_mdu #(.XLEN(XLEN)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_mext     (i_mext),
        .i_opsel    (i_opsel),
        .i_sub      (i_sub),
        .i_unsigned (i_unsigned),
        .i_arith    (i_arith),
        .i_op1      (i_op1),
        .i_op2      (i_op2),
        .o_valid    (o_valid),
        .o_result   (o_result),
        .o_eq       (o_eq),
        .o_slt      (o_slt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string       name;
        logic        mext;
        logic [2:0]  sel;
        logic        sub;
        logic        uns;
        logic        arith;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic lt_ref(input logic uns, input logic [31:0] a, input logic [31:0] b);
        return uns ? (a < b) : ($signed(a) < $signed(b));
    endfunction

    function automatic bit div_special(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        return sel[2] && ((b == 32'd0) || (!sel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic int lat_ref(input logic mext, input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        if (!mext || div_special(sel, a, b)) return 1;
        return XLEN + 1;
    endfunction

    // Behavioural result model using wide arithmetic
    function automatic logic [31:0] model(input logic mext, input logic [2:0] sel, input logic sub,
                                          input logic uns, input logic arith,
                                          input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        if (!mext) begin
            case (sel)
                3'd0: return sub ? a - b : a + b;
                3'd1: return a << b[4:0];
                3'd2, 3'd3: return {31'd0, lt_ref(uns, a, b)};
                3'd4: return a ^ b;
                3'd5: return arith ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
                3'd6: return a | b;
                default: return a & b;
            endcase
        end
        case (sel)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic vec_t mk(input string name, input logic mext, input logic [2:0] sel,
                                input logic sub, input logic uns, input logic arith,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input int lat);
        vec_t v;
        v.name = name; v.mext = mext; v.sel = sel; v.sub = sub; v.uns = uns;
        v.arith = arith; v.a = a; v.b = b; v.res = res; v.lat = lat;
        return v;
    endfunction

    // Issue one request (called just after a rising edge) and check its completion
    task automatic do_op(input string name, input logic mext, input logic [2:0] sel,
                         input logic sub, input logic uns, input logic arith,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input bit noise);
        int lat;
        bit ready_ok;
        check({name, " ready_at_issue"}, 64'(o_ready), 64'd1);
        i_valid = 1'b1; i_mext = mext; i_opsel = sel; i_sub = sub;
        i_unsigned = uns; i_arith = arith; i_op1 = a; i_op2 = b;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        lat = 1;
        ready_ok = 1'b1;
        while (!o_valid && lat < 100) begin
            if (o_ready !== 1'b0) ready_ok = 1'b0;
            if (noise) begin
                i_valid = 1'b1; i_mext = 1'($urandom); i_opsel = 3'($urandom);
                i_op1 = $urandom; i_op2 = $urandom; i_unsigned = 1'($urandom);
            end
            @(posedge i_clk); #1;
            lat++;
        end
        i_valid = 1'b0;
        check({name, " valid"}, 64'(o_valid), 64'd1);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " result"}, 64'(o_result), 64'(exp_res));
        check({name, " eq"}, 64'(o_eq), 64'(a == b));
        check({name, " slt"}, 64'(o_slt), 64'(lt_ref(uns, a, b)));
        if (exp_lat > 1) check({name, " ready_low_busy"}, 64'(ready_ok), 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb, last_res;
        logic [2:0]  rsel;
        logic        rmext, rsub, runs, rar;
        bit          seen;

        i_rst = 1'b1; i_valid = 1'b0; i_mext = 1'b0; i_opsel = '0; i_sub = 1'b0;
        i_unsigned = 1'b0; i_arith = 1'b0; i_op1 = '0; i_op2 = '0;

        repeat (3) @(posedge i_clk);
        #1;
        check("reset ready_in_reset", 64'(o_ready), 64'd0);
        check("reset valid", 64'(o_valid), 64'd0);
        i_rst = 1'b0;
        #1;
        check("reset ready_after", 64'(o_ready), 64'd1);
        check("reset result", 64'(o_result), 64'd0);
        check("reset eq", 64'(o_eq), 64'd0);
        check("reset slt", 64'(o_slt), 64'd0);
        @(posedge i_clk); #1;

        tbl.push_back(mk("add",      0, 3'b000, 0, 0, 0, 32'd5,          32'd7,          32'd12,         1));
        tbl.push_back(mk("sra",      0, 3'b101, 0, 0, 1, 32'h8000_0000,  32'd4,          32'hF800_0000,  1));
        tbl.push_back(mk("mulhu",    1, 3'b011, 0, 0, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33));
        tbl.push_back(mk("mulh",     1, 3'b001, 0, 0, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000,  33));
        tbl.push_back(mk("mulhsu",   1, 3'b010, 0, 0, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  33));
        tbl.push_back(mk("mul",      1, 3'b000, 0, 0, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  33));
        tbl.push_back(mk("div",      1, 3'b100, 0, 0, 0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33));
        tbl.push_back(mk("rem",      1, 3'b110, 0, 0, 0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33));
        tbl.push_back(mk("divu",     1, 3'b101, 0, 0, 0, 32'd100,        32'd7,          32'd14,         33));
        tbl.push_back(mk("remu",     1, 3'b111, 0, 0, 0, 32'd100,        32'd7,          32'd2,          33));
        tbl.push_back(mk("divu_z",   1, 3'b101, 0, 0, 0, 32'd100,        32'd0,          32'hFFFF_FFFF,  1));
        tbl.push_back(mk("remu_z",   1, 3'b111, 0, 0, 0, 32'd100,        32'd0,          32'd100,        1));
        tbl.push_back(mk("div_ovf",  1, 3'b100, 0, 0, 0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1));
        tbl.push_back(mk("rem_ovf",  1, 3'b110, 0, 0, 0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1));
        tbl.push_back(mk("div_z",    1, 3'b100, 0, 0, 0, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1));
        tbl.push_back(mk("rem_z",    1, 3'b110, 0, 0, 0, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1));
        tbl.push_back(mk("sub",      0, 3'b000, 1, 0, 0, 32'd3,          32'd5,          32'hFFFF_FFFE,  1));
        tbl.push_back(mk("sltu",     0, 3'b011, 0, 1, 0, 32'd1,          32'hFFFF_FFFF,  32'd1,          1));
        tbl.push_back(mk("slt",      0, 3'b010, 0, 0, 0, 32'd1,          32'hFFFF_FFFF,  32'd0,          1));
        tbl.push_back(mk("sll",      0, 3'b001, 0, 0, 0, 32'd1,          32'd31,         32'h8000_0000,  1));
        tbl.push_back(mk("srl",      0, 3'b101, 0, 0, 0, 32'h8000_0000,  32'd36,         32'h0800_0000,  1));
        tbl.push_back(mk("and_eq",   0, 3'b111, 0, 0, 0, 32'h1234_5678,  32'h1234_5678,  32'h1234_5678,  1));

        // Directed table, issued back to back
        foreach (tbl[i]) begin
            do_op(tbl[i].name, tbl[i].mext, tbl[i].sel, tbl[i].sub, tbl[i].uns, tbl[i].arith,
                  tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat, 1'b0);
        end
        last_res = tbl[tbl.size()-1].res;

        // Outputs hold while idle
        repeat (3) @(posedge i_clk);
        #1;
        check("hold valid", 64'(o_valid), 64'd0);
        check("hold result", 64'(o_result), 64'(last_res));
        @(posedge i_clk); #1;

        // Requests offered while busy are ignored; inputs are don't-care after accept
        do_op("divu_noise", 1, 3'b101, 0, 0, 0, 32'd1000, 32'd3, 32'd333, 33, 1'b1);
        do_op("mul_noise", 1, 3'b000, 0, 0, 0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 33, 1'b1);

        // Reset during iteration aborts the divide
        i_valid = 1'b1; i_mext = 1'b1; i_opsel = 3'b100; i_op1 = 32'd100; i_op2 = 32'd7;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (9) begin
            @(posedge i_clk); #1;
        end
        check("abort busy", 64'(o_ready), 64'd0);
        i_rst = 1'b1;
        #1;
        check("abort ready_in_reset", 64'(o_ready), 64'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        #1;
        check("abort ready_after", 64'(o_ready), 64'd1);
        check("abort result_cleared", 64'(o_result), 64'd0);
        seen = 1'b0;
        if (o_valid) seen = 1'b1;
        repeat (40) begin
            @(posedge i_clk); #1;
            if (o_valid) seen = 1'b1;
        end
        check("abort no_valid", 64'(seen), 64'd0);
        do_op("add_after_abort", 0, 3'b000, 0, 0, 0, 32'd1, 32'd1, 32'd2, 1, 1'b0);

        // Random requests against the model
        for (int n = 0; n < 80; n++) begin
            rmext = 1'($urandom);
            rsel  = 3'($urandom);
            rsub  = 1'($urandom);
            runs  = 1'($urandom);
            rar   = 1'($urandom);
            ra    = pick();
            rb    = pick();
            do_op($sformatf("rnd%0d_m%0d_s%0d", n, rmext, rsel), rmext, rsel, rsub, runs, rar, ra, rb,
                  model(rmext, rsel, rsub, runs, rar, ra, rb),
                  lat_ref(rmext, rsel, ra, rb), ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Sequential, XLEN-parametrised successor to the single-cycle ALU. It executes all base integer ops (add/sub, shifts, slt/sltu, logic) with a registered one-cycle result. It adds the RV32M multiply/divide group through an iterative shift-add multiplier and a restoring divider. It sits in the execute stage behind a valid/ready handshake, so the core can stall on multi-cycle M-extension instructions.

## Interface
- XLEN, 32: operand/result width; must be a power of two, ≥ 8.
- SHW, $clog2(XLEN): derived shift-amount width; not overridable.

- i_clk  in  1  single clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  request present.
- o_ready  out  1  block can accept a request this cycle.
- i_mext  in  1  0: base op; 1: M-extension op selected by i_opsel.
- i_opsel  in  3  base: 000 add/sub, 001 sll, 01x slt, 100 xor, 101 srl/sra, 110 or, 111 and; mext: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_sub  in  1  subtract, for base 000 only.
- i_unsigned  in  1  unsigned compare for slt and o_slt.
- i_arith  in  1  arithmetic right shift, for base 101 only.
- i_op1, i_op2  in  XLEN  operands.
- o_valid  out  1  one-cycle pulse; result outputs are valid.
- o_result  out  XLEN  result.
- o_eq  out  1  op1 == op2 for the accepted request.
- o_slt  out  1  op1 < op2, signed or unsigned per i_unsigned.

## Operation
- Accept: a request is accepted when i_valid && o_ready. All inputs are captured then; they are don't-care afterward.
- FSM states:
  - IDLE: o_ready=1.
  - MUL: o_ready=0.
  - DIV: o_ready=0.
  - DONE: o_valid=1, o_ready=1.
- FSM transitions:
  - IDLE/DONE + accept base op → DONE.
  - IDLE/DONE + accept MUL* → MUL.
  - IDLE/DONE + accept DIV/REM* → DIV, or → DONE for a special case.
  - DONE without accept → IDLE.
  - MUL/DIV → DONE after XLEN iterations.
- Base ops: same semantics as the existing ALU. The shift amount is i_op2[SHW-1:0]. Carry is discarded. slt writes 1 or 0 zero-extended.
- o_eq and o_slt are computed from the captured operands for every request, including M ops, and registered with o_result.
- Multiply:
  - Operands are converted to magnitudes. MUL/MULH treat both as signed, MULHSU treats op1 as signed, MULHU treats both as unsigned.
  - A 2·XLEN product accumulates by shift-add, 1 bit per cycle, over XLEN cycles.
  - The product is negated at finalise if the sign flags differ.
  - MUL returns the low XLEN bits; the MULH* ops return the high XLEN bits.
- Divide:
  - Unsigned restoring division on magnitudes, 1 quotient bit per cycle.
  - Quotient is negated if the signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
- Special cases, resolved at accept with no iteration:
  - divisor = 0: quotient = all-ones; remainder = op1.
  - Signed DIV/REM with op1 = 1<<(XLEN-1) and op2 = all-ones: quotient = op1; remainder = 0.
- Iteration counter: SHW+1 bits; loaded with XLEN at entry to MUL/DIV and decremented each cycle; the FSM leaves on 1→0.

## Timing
- Accept at edge N. o_valid is high during cycle:
  - N+1 for base ops and divide special cases;
  - N+XLEN+1 for iterative ops (33 for XLEN=32). Finalise/sign-fix happens on the last iteration edge.
- Back-to-back: a request may be accepted in the DONE cycle. Base-op throughput is 1/cycle.
- o_result, o_eq and o_slt hold their value until the next o_valid pulse.
- Reset values: state IDLE, o_valid 0, o_ready 0 while i_rst is high and 1 the cycle after, o_result 0, o_eq 0, o_slt 0, counter 0.
- Reset mid-iteration aborts the op: no o_valid is produced and partial state is cleared.
- i_valid while busy is ignored; the requester must hold the request until o_ready.

## Structure
- Shared package alu_pkg:
  - base opsel localparams;
  - M funct3 localparams;
  - FSM state enum (IDLE/MUL/DIV/DONE).
- Sub-module muldiv_core holds the accumulator, quotient and remainder registers, the counter, and the sign handling.
- The base-op datapath and FSM stay in alu_mdu.

## Test plan
All values for XLEN=32.
- ADD 5 + 7, i_sub=0 → o_valid at N+1, o_result=12, o_eq=0, o_slt=1. Repeat in the DONE cycle with sra 0x80000000>>4, i_arith=1 → 0xF8000000 the next cycle.
- MULHU 0xFFFFFFFF·0xFFFFFFFF → 0xFFFFFFFE at N+33. With the same operands:
  - MULH → 0x00000000;
  - MULHSU → 0xFFFFFFFF;
  - MUL → 0x00000001.
- DIV −7/2 → 0xFFFFFFFD and REM → 0xFFFFFFFF. DIVU 100/7 → 14 and REMU → 2. All at N+33, with o_ready=0 throughout the iterations.
- DIVU 100/0 → 0xFFFFFFFF and REMU 100/0 → 100, both at N+1.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0, both at N+1.
- i_rst pulsed during iteration 10 of a DIV → o_valid never pulses and o_ready=1 on the first post-reset cycle. A following ADD 1+1 → 2 at N+1.
